// File: rtl/fp32_adder_if.sv
// Operand/result bundle for fp32_adder: two stb/ack operand channels and one stb/ack result channel.
// FP32_ADDER_SUB_EN adds input_b_neg, which travels with operand B.
interface fp32_adder_if;
    logic [31:0] input_a;
    logic        input_a_stb;
    logic        input_a_ack;
    logic [31:0] input_b;
    logic        input_b_stb;
    logic        input_b_ack;
    logic [31:0] output_z;
    logic        output_z_stb;
    logic        output_z_ack;
`ifdef FP32_ADDER_SUB_EN
    logic        input_b_neg;

    modport master (
        output input_a, input_a_stb, input_b, input_b_stb, input_b_neg, output_z_ack,
        input  input_a_ack, input_b_ack, output_z, output_z_stb
    );
    modport slave (
        input  input_a, input_a_stb, input_b, input_b_stb, input_b_neg, output_z_ack,
        output input_a_ack, input_b_ack, output_z, output_z_stb
    );
`else
    modport master (
        output input_a, input_a_stb, input_b, input_b_stb, output_z_ack,
        input  input_a_ack, input_b_ack, output_z, output_z_stb
    );
    modport slave (
        input  input_a, input_a_stb, input_b, input_b_stb, output_z_ack,
        output input_a_ack, input_b_ack, output_z, output_z_stb
    );
`endif
endinterface

// File: rtl/fp32_adder.sv
// IEEE-754 float32 adder (round-to-nearest-even), one op in flight; Z valid 3 cycles (specials) to ~40 cycles after B accept.
// A then B accepted on stb/ack, Z held until output_z_ack. Define FP32_ADDER_SUB_EN for input_b_neg (Z = A - B).
module fp32_adder #(
    parameter logic [31:0] CANON_NAN = 32'h7FC00000
) (
    input logic         clk,
    input logic         rst,
    fp32_adder_if.slave bus
);
    typedef enum logic [3:0] {
        GET_A, GET_B, UNPACK, SPECIAL, ALIGN, ADD, NORM, ROUND, PACK, PUT_Z
    } state_t;

    localparam logic signed [9:0] EMIN = -10'sd126;
    localparam logic signed [9:0] EMAX = 10'sd127;

    state_t            state_q, state_d;
    logic              a_ack_q, a_ack_d, b_ack_q, b_ack_d, z_stb_q, z_stb_d;
    logic [31:0]       z_q, z_d, a_raw_q, a_raw_d, b_raw_q, b_raw_d;
    // Mantissas carry hidden bit, 23 fraction bits, then guard/round/sticky.
    logic [26:0]       a_m_q, a_m_d, b_m_q, b_m_d;
    logic [27:0]       z_m_q, z_m_d;
    logic signed [9:0] a_e_q, a_e_d, b_e_q, b_e_d, z_e_q, z_e_d;
    logic              z_s_q, z_s_d;

    logic [31:0]       b_in;
    logic signed [9:0] a_e_unp, b_e_unp;
    logic              a_nan, a_inf, a_zero, b_nan, b_inf, b_zero;
    logic              same_sign, a_ge_b, add_sign, rnd_up;
    logic [27:0]       add_sum;
    logic [24:0]       rnd_mant;
    logic [7:0]        z_bias;

`ifdef FP32_ADDER_SUB_EN
    assign b_in = {bus.input_b[31] ^ bus.input_b_neg, bus.input_b[30:0]};
`else
    assign b_in = bus.input_b;
`endif

    assign a_e_unp = (a_raw_q[30:23] == 8'd0) ? EMIN : ($signed({2'b00, a_raw_q[30:23]}) - 10'sd127);
    assign b_e_unp = (b_raw_q[30:23] == 8'd0) ? EMIN : ($signed({2'b00, b_raw_q[30:23]}) - 10'sd127);

    assign a_nan  = (&a_raw_q[30:23]) &  (|a_raw_q[22:0]);
    assign a_inf  = (&a_raw_q[30:23]) & ~(|a_raw_q[22:0]);
    assign a_zero = ~(|a_raw_q[30:0]);
    assign b_nan  = (&b_raw_q[30:23]) &  (|b_raw_q[22:0]);
    assign b_inf  = (&b_raw_q[30:23]) & ~(|b_raw_q[22:0]);
    assign b_zero = ~(|b_raw_q[30:0]);

    // Unlike signs subtract the smaller magnitude; the larger one's sign wins.
    assign same_sign = a_raw_q[31] == b_raw_q[31];
    assign a_ge_b    = a_m_q >= b_m_q;
    assign add_sum   = same_sign ? ({1'b0, a_m_q} + {1'b0, b_m_q}) :
                       a_ge_b    ? ({1'b0, a_m_q} - {1'b0, b_m_q}) :
                                   ({1'b0, b_m_q} - {1'b0, a_m_q});
    assign add_sign  = (same_sign || a_ge_b) ? a_raw_q[31] : b_raw_q[31];

    assign rnd_up   = z_m_q[2] & (z_m_q[1] | z_m_q[0] | z_m_q[3]);
    assign rnd_mant = {1'b0, z_m_q[26:3]} + 25'd1;
    assign z_bias   = z_e_q[7:0] + 8'd127;

    always_comb begin
        state_d = state_q;
        a_ack_d = a_ack_q;
        b_ack_d = b_ack_q;
        z_stb_d = z_stb_q;
        z_d     = z_q;
        a_raw_d = a_raw_q;
        b_raw_d = b_raw_q;
        a_m_d   = a_m_q;
        b_m_d   = b_m_q;
        a_e_d   = a_e_q;
        b_e_d   = b_e_q;
        z_m_d   = z_m_q;
        z_e_d   = z_e_q;
        z_s_d   = z_s_q;
        case (state_q)
            GET_A: begin
                a_ack_d = 1'b1;
                if (a_ack_q && bus.input_a_stb) begin
                    a_raw_d = bus.input_a;
                    a_ack_d = 1'b0;
                    b_ack_d = 1'b1;
                    state_d = GET_B;
                end
            end
            GET_B: begin
                b_ack_d = 1'b1;
                if (b_ack_q && bus.input_b_stb) begin
                    b_raw_d = b_in;
                    b_ack_d = 1'b0;
                    state_d = UNPACK;
                end
            end
            UNPACK: begin
                a_m_d   = {a_raw_q[30:23] != 8'd0, a_raw_q[22:0], 3'b000};
                b_m_d   = {b_raw_q[30:23] != 8'd0, b_raw_q[22:0], 3'b000};
                a_e_d   = a_e_unp;
                b_e_d   = b_e_unp;
                state_d = SPECIAL;
            end
            SPECIAL: begin
                z_stb_d = 1'b1;
                state_d = PUT_Z;
                if (a_nan || b_nan || (a_inf && b_inf && !same_sign)) z_d = CANON_NAN;
                else if (a_inf)             z_d = a_raw_q;
                else if (b_inf)             z_d = b_raw_q;
                else if (a_zero && b_zero)  z_d = {a_raw_q[31] & b_raw_q[31], 31'd0};
                else if (a_zero)            z_d = b_raw_q;
                else if (b_zero)            z_d = a_raw_q;
                else begin
                    z_stb_d = 1'b0;
                    state_d = ALIGN;
                end
            end
            ALIGN: begin
                // Once only sticky is left further shifts change nothing.
                if (a_e_q > b_e_q) begin
                    if (b_m_q[26:1] == 26'd0) state_d = ADD;
                    else begin
                        b_m_d = {1'b0, b_m_q[26:2], b_m_q[1] | b_m_q[0]};
                        b_e_d = b_e_q + 10'sd1;
                    end
                end else if (b_e_q > a_e_q) begin
                    if (a_m_q[26:1] == 26'd0) state_d = ADD;
                    else begin
                        a_m_d = {1'b0, a_m_q[26:2], a_m_q[1] | a_m_q[0]};
                        a_e_d = a_e_q + 10'sd1;
                    end
                end else begin
                    state_d = ADD;
                end
            end
            ADD: begin
                z_m_d = add_sum;
                z_s_d = add_sign;
                z_e_d = (a_e_q > b_e_q) ? a_e_q : b_e_q;
                if (add_sum == 28'd0) begin
                    z_d     = 32'd0;
                    z_stb_d = 1'b1;
                    state_d = PUT_Z;
                end else begin
                    state_d = NORM;
                end
            end
            NORM: begin
                if (z_m_q[27] || z_e_q < EMIN) begin
                    z_m_d = {1'b0, z_m_q[27:2], z_m_q[1] | z_m_q[0]};
                    z_e_d = z_e_q + 10'sd1;
                end else if (!z_m_q[26] && z_e_q > EMIN) begin
                    z_m_d = {z_m_q[26:0], 1'b0};
                    z_e_d = z_e_q - 10'sd1;
                end else begin
                    state_d = ROUND;
                end
            end
            ROUND: begin
                if (rnd_up) begin
                    if (rnd_mant[24]) begin
                        z_m_d = 28'h4000000;
                        z_e_d = z_e_q + 10'sd1;
                    end else begin
                        z_m_d = {1'b0, rnd_mant[23:0], 3'b000};
                    end
                end
                state_d = PACK;
            end
            PACK: begin
                if (z_e_q > EMAX)                     z_d = {z_s_q, 8'hFF, 23'd0};
                else if (z_e_q == EMIN && !z_m_q[26]) z_d = {z_s_q, 8'h00, z_m_q[25:3]};
                else                                  z_d = {z_s_q, z_bias, z_m_q[25:3]};
                z_stb_d = 1'b1;
                state_d = PUT_Z;
            end
            PUT_Z: begin
                if (z_stb_q && bus.output_z_ack) begin
                    z_stb_d = 1'b0;
                    a_ack_d = 1'b1;
                    state_d = GET_A;
                end
            end
            default: state_d = GET_A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= GET_A;
            a_ack_q <= 1'b0;
            b_ack_q <= 1'b0;
            z_stb_q <= 1'b0;
            z_q     <= 32'd0;
            a_raw_q <= 32'd0;
            b_raw_q <= 32'd0;
            a_m_q   <= 27'd0;
            b_m_q   <= 27'd0;
            a_e_q   <= 10'sd0;
            b_e_q   <= 10'sd0;
            z_m_q   <= 28'd0;
            z_e_q   <= 10'sd0;
            z_s_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_ack_q <= a_ack_d;
            b_ack_q <= b_ack_d;
            z_stb_q <= z_stb_d;
            z_q     <= z_d;
            a_raw_q <= a_raw_d;
            b_raw_q <= b_raw_d;
            a_m_q   <= a_m_d;
            b_m_q   <= b_m_d;
            a_e_q   <= a_e_d;
            b_e_q   <= b_e_d;
            z_m_q   <= z_m_d;
            z_e_q   <= z_e_d;
            z_s_q   <= z_s_d;
        end
    end

    assign bus.input_a_ack  = a_ack_q;
    assign bus.input_b_ack  = b_ack_q;
    assign bus.output_z_stb = z_stb_q;
    assign bus.output_z     = z_q;
endmodule

// File: tb/tb_fp32_adder.sv
// Bench for fp32_adder: exact-arithmetic reference model, directed vectors, handshake hold and abort.
module tb_fp32_adder;
    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    fp32_adder_if bus();

    fp32_adder #(.CANON_NAN(32'h7FC00000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        neg;
        logic [31:0] z;
    } vec_t;

    localparam int NV = 25;
    vec_t vecs [NV] = '{
        '{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000},
        '{32'h3F800000, 32'hBF800000, 1'b0, 32'h00000000},
        '{32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000},
        '{32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000},
        '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000},
        '{32'h80000000, 32'h00000000, 1'b0, 32'h00000000},
        '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000},
        '{32'h00000001, 32'h00000001, 1'b0, 32'h00000002},
        '{32'h00800000, 32'h80000001, 1'b0, 32'h007FFFFF},
        '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000},
        '{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002},
        '{32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000},
        '{32'h3F800000, 32'hFF800000, 1'b0, 32'hFF800000},
        '{32'h00000000, 32'hC0490FDB, 1'b0, 32'hC0490FDB},
        '{32'h3F800001, 32'hBF800000, 1'b0, 32'h34000000},
        '{32'h3F800000, 32'hB3000000, 1'b0, 32'h3F800000},
        '{32'h4B000000, 32'h3F000000, 1'b0, 32'h4B000000},
        '{32'h4B000001, 32'h3F000000, 1'b0, 32'h4B000002},
        '{32'hC0A00000, 32'h40400000, 1'b0, 32'hC0000000},
        '{32'h00000000, 32'h80000000, 1'b0, 32'h00000000},
        '{32'hFF800000, 32'hFF800000, 1'b0, 32'hFF800000},
        '{32'h807FFFFF, 32'h807FFFFF, 1'b0, 32'h80FFFFFE},
        '{32'h7F800001, 32'h7F800000, 1'b0, 32'h7FC00000},
        '{32'h40400000, 32'h3F800000, 1'b1, 32'h40000000},
        '{32'h7FC00000, 32'h3F800000, 1'b1, 32'h7FC00000}
    };

    // Exact sum on a 2^-149 grid, then a single round-to-nearest-even.
    function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
        logic         sa, sb, sz;
        logic [7:0]   ea, eb;
        logic [299:0] ma, mb, mag, rem, half;
        logic [24:0]  mant;
        int           p, sh, e;
        sa = a[31]; sb = b[31]; ea = a[30:23]; eb = b[30:23];
        if ((ea == 8'hFF && a[22:0] != 0) || (eb == 8'hFF && b[22:0] != 0)) return 32'h7FC00000;
        if (ea == 8'hFF && eb == 8'hFF && sa != sb) return 32'h7FC00000;
        if (ea == 8'hFF) return a;
        if (eb == 8'hFF) return b;
        if (a[30:0] == 0 && b[30:0] == 0) return {sa & sb, 31'd0};
        if (a[30:0] == 0) return b;
        if (b[30:0] == 0) return a;
        ma = {276'd0, ea != 0, a[22:0]} << ((ea == 0) ? 0 : int'(ea) - 1);
        mb = {276'd0, eb != 0, b[22:0]} << ((eb == 0) ? 0 : int'(eb) - 1);
        if (sa == sb)      begin mag = ma + mb; sz = sa; end
        else if (ma >= mb) begin mag = ma - mb; sz = sa; end
        else               begin mag = mb - ma; sz = sb; end
        if (mag == 0) return 32'd0;
        p = 0;
        for (int i = 0; i < 300; i++) if (mag[i]) p = i;
        if (p <= 23) return {sz, mag[30:0]};
        sh   = p - 23;
        mant = 25'(mag >> sh);
        rem  = mag & ((300'd1 << sh) - 300'd1);
        half = 300'd1 << (sh - 1);
        if (rem > half || (rem == half && mant[0])) mant = mant + 25'd1;
        e = sh + 1;
        if (mant[24]) begin mant = mant >> 1; e = e + 1; end
        if (e >= 255) return {sz, 8'hFF, 23'd0};
        return {sz, 8'(e), mant[22:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    task automatic wait_sig(input int w, input int limit, input string name, output int n);
        logic s;
        n = 0;
        s = (w == 0) ? bus.input_a_ack : (w == 1) ? bus.input_b_ack : bus.output_z_stb;
        while (s !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
            s = (w == 0) ? bus.input_a_ack : (w == 1) ? bus.input_b_ack : bus.output_z_stb;
        end
        n_vec++;
        if (n >= limit) begin
            n_err++;
            $display("FAIL %s: no response after %0d cycles, limit %0d", name, n, limit);
        end
    endtask

    task automatic send_ab(input logic [31:0] a, input logic [31:0] b, input logic neg, input string name);
        int n;
        bus.input_a = a;
        bus.input_a_stb = 1'b1;
        wait_sig(0, 100, {name, " a_ack"}, n);
        @(negedge clk);
        bus.input_a_stb = 1'b0;
        bus.input_b = b;
        bus.input_b_stb = 1'b1;
`ifdef FP32_ADDER_SUB_EN
        bus.input_b_neg = neg;
`else
        if (neg) $display("note: %s requests subtract in an add-only build", name);
`endif
        wait_sig(1, 100, {name, " b_ack"}, n);
    endtask

    task automatic op(input logic [31:0] a, input logic [31:0] b, input logic neg,
                      input int hold, input logic has_lit, input logic [31:0] lit, input string name);
        logic [31:0] want;
        int n, lat;
        want = ref_add(a, neg ? {~b[31], b[30:0]} : b);
        if (has_lit) check({name, " model"}, want, lit);
        bus.output_z_ack = (hold == 0);
        send_ab(a, b, neg, name);
        exp_q.push_back(want);
        @(negedge clk);
        bus.input_b_stb = 1'b0;
        wait_sig(2, 70, {name, " z_stb"}, n);
        lat = n + 1;
        n_vec++;
        if (lat < 3 || lat > 64) begin
            n_err++;
            $display("FAIL %s latency: %0d cycles, allowed 3..64", name, lat);
        end
        for (int i = 0; i < hold; i++) begin
            check({name, " z_stb held"}, {31'd0, bus.output_z_stb}, 32'd1);
            @(negedge clk);
        end
        bus.output_z_ack = 1'b1;
        n = 0;
        while (bus.output_z_stb === 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        n_vec++;
        if (n >= 10) begin
            n_err++;
            $display("FAIL %s z_stb release: still high after %0d cycles", name, n);
        end
    endtask

    initial begin
        int n;
        logic [31:0] ra, rb;
        logic [7:0]  reb;
        rst = 1'b1;
        bus.input_a = 32'd0;
        bus.input_a_stb = 1'b0;
        bus.input_b = 32'd0;
        bus.input_b_stb = 1'b0;
        bus.output_z_ack = 1'b1;
`ifdef FP32_ADDER_SUB_EN
        bus.input_b_neg = 1'b0;
`endif
        fork
            forever begin
                @(negedge clk);
                #1;
                if (rst === 1'b0 && bus.output_z_stb === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected z_stb: output_z=%h with no operation outstanding", bus.output_z);
                    end else begin
                        check("output_z", bus.output_z, exp_q[0]);
                        if (bus.output_z_ack === 1'b1) void'(exp_q.pop_front());
                    end
                end
            end
        join_none

        repeat (3) @(negedge clk);
        check("reset a_ack", {31'd0, bus.input_a_ack}, 32'd0);
        check("reset b_ack", {31'd0, bus.input_b_ack}, 32'd0);
        check("reset z_stb", {31'd0, bus.output_z_stb}, 32'd0);
        check("reset z", bus.output_z, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("a_ack after reset", {31'd0, bus.input_a_ack}, 32'd1);

        for (int i = 0; i < NV; i++) begin
`ifndef FP32_ADDER_SUB_EN
            if (vecs[i].neg) continue;
`endif
            op(vecs[i].a, vecs[i].b, vecs[i].neg, 0, 1'b1, vecs[i].z, $sformatf("vec%0d", i));
        end

        op(32'h40490FDB, 32'h3F800000, 1'b0, 10, 1'b1, 32'h408487EE, "hold");

        // Abort while the 2^-24 addend is still being aligned.
        bus.output_z_ack = 1'b1;
        send_ab(32'h3F800000, 32'h33800000, 1'b0, "abort");
        @(negedge clk);
        bus.input_b_stb = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort a_ack", {31'd0, bus.input_a_ack}, 32'd0);
        check("abort b_ack", {31'd0, bus.input_b_ack}, 32'd0);
        check("abort z_stb", {31'd0, bus.output_z_stb}, 32'd0);
        check("abort z", bus.output_z, 32'd0);
        rst = 1'b0;
        op(32'h3F800001, 32'h33800000, 1'b0, 0, 1'b1, 32'h3F800002, "after abort");

        for (int i = 0; i < 150; i++) begin
            ra = $urandom;
            if (i % 2 == 0) begin
                rb = $urandom;
            end else begin
                reb = ra[30:23] ^ 8'($urandom_range(0, 3));
                rb  = {1'($urandom_range(0, 1)), reb, 23'($urandom)};
            end
            op(ra, rb, 1'b0, 0, 1'b0, 32'd0, $sformatf("rnd%0d", i));
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
